// File: rtl/fsm_pkg.sv
// Shared definitions for the binary-to-decimal seven-segment display driver.
// Holds the conversion FSM state type, BCD geometry, the active-low segment
// patterns (written g..a, bit0 = a) and the double-dabble nibble adjust helper.
package fsm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } state_e;

  localparam int unsigned DIGITS      = 5;
  localparam int unsigned SHIFT_COUNT = 16;
  localparam int unsigned BCD_W       = 4 * DIGITS;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] BLANK = 7'b1111111;

  // One double-dabble correction: every BCD nibble >= 5 gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to seven-segment decoder (active-low segments).
// Ports:
//   digit_i   - BCD digit 0..9 (10..15 decode to blank)
//   blank_i   - force all segments off
//   cathode_o - segment drive, bit0 = a .. bit6 = g, active-low
module seg7_decode
  import fsm_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] cathode_o
);

  always_comb begin
    cathode_o = BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    cathode_o = SEG_0;
        4'd1:    cathode_o = SEG_1;
        4'd2:    cathode_o = SEG_2;
        4'd3:    cathode_o = SEG_3;
        4'd4:    cathode_o = SEG_4;
        4'd5:    cathode_o = SEG_5;
        4'd6:    cathode_o = SEG_6;
        4'd7:    cathode_o = SEG_7;
        4'd8:    cathode_o = SEG_8;
        4'd9:    cathode_o = SEG_9;
        default: cathode_o = BLANK;
      endcase
    end
  end

endmodule

// File: rtl/fsm.sv
// 16-bit binary to 5-digit decimal multiplexed seven-segment display driver.
// A three-state FSM (idle/shift/latch) runs a serial double-dabble conversion
// every 18 cycles; a scan divider cycles the five digit slots.
// Ports:
//   clock              - single clock, rising edge
//   reset              - asynchronous, active-high
//   sixteen_bit_number - unsigned value to display
//   cathode            - segment drive, active-low, bit0 = a .. bit6 = g (registered)
//   anode              - digit enable, active-low one-hot, bit0 = ones (registered)
module fsm
  import fsm_pkg::*;
#(
  parameter int unsigned REFRESH_COUNT = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] sixteen_bit_number,
  output logic [6:0]  cathode,
  output logic [7:0]  anode
);

  localparam int unsigned DivW = 20;

  // Conversion datapath
  state_e           state_q;
  logic [15:0]      bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;
  logic [3:0]       cnt_q;
  logic [BCD_W-1:0] disp_q;

  // Scan datapath
  logic [DivW-1:0]  div_q, div_d;
  logic [2:0]       scan_q, scan_d;
  logic [BCD_W-1:0] upper;
  logic [3:0]       cur_digit;
  logic             cur_blank;
  logic [6:0]       seg_pattern;
  logic [7:0]       anode_d;
  logic [6:0]       cathode_q;
  logic [7:0]       anode_q;

  assign bcd_adj = dabble_adjust(bcd_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          bin_q   <= sixteen_bit_number;
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= StShift;
        end
        StShift: begin
          // Adjust, then shift the whole {bcd, bin} chain left by one.
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q + 4'd1;
          if (cnt_q == 4'(SHIFT_COUNT - 1)) begin
            state_q <= StLatch;
          end
        end
        StLatch: begin
          disp_q  <= bcd_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    div_d  = div_q + 20'd1;
    scan_d = scan_q;
    if (div_q == DivW'(REFRESH_COUNT - 1)) begin
      div_d  = '0;
      scan_d = (scan_q == 3'(DIGITS - 1)) ? 3'd0 : scan_q + 3'd1;
    end
  end

  // Digits from the scanned slot upward; the slot is blank when all of them
  // are zero, except slot 0 which always shows its digit.
  always_comb begin
    upper     = disp_q >> {scan_q, 2'b00};
    cur_digit = upper[3:0];
    cur_blank = (scan_q != 3'd0) && (upper == '0);
    anode_d   = ~(8'b0000_0001 << scan_q);
  end

  seg7_decode u_seg7_decode (
    .digit_i  (cur_digit),
    .blank_i  (cur_blank),
    .cathode_o(seg_pattern)
  );

  // Anode and cathode come from the same scan index and update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      scan_q    <= '0;
      anode_q   <= 8'hFF;
      cathode_q <= 7'h7F;
    end else begin
      div_q     <= div_d;
      scan_q    <= scan_d;
      anode_q   <= anode_d;
      cathode_q <= seg_pattern;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule

// File: tb/tb_fsm.sv
module tb_fsm;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000;
  localparam logic [6:0] PB = 7'b1111111;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] num;
  logic [6:0]  cathode;
  logic [7:0]  anode;

  int vectors     = 0;
  int miscompares = 0;
  int bad_anode   = 0;
  int bad_pat     = 0;

  fsm #(.REFRESH_COUNT(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .sixteen_bit_number(num),
    .cathode           (cathode),
    .anode             (anode)
  );

  always #5 clock = ~clock;

  function automatic bit legal_pat(input logic [6:0] c);
    return c inside {P0, P1, P2, P3, P4, P5, P6, P7, P8, P9, PB};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for the slot then checks its pattern.
  task automatic slot(input string tag, input logic [7:0] target, input logic [6:0] exp_cat);
    for (int i = 0; i < 60; i++) begin
      if (anode === target) break;
      @(negedge clock);
    end
    check({tag, "_anode"}, 32'(anode), 32'(target));
    check({tag, "_cathode"}, 32'(cathode), 32'(exp_cat));
  endtask

  // Continuous legality monitor: one-hot anode within bits 0..4, known patterns.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (!(anode inside {8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF})) bad_anode++;
      if (!legal_pat(cathode)) bad_pat++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    num   = 16'd0;
    repeat (2) @(negedge clock);
    check("rst_anode", 32'(anode), 32'hFF);
    check("rst_cathode", 32'(cathode), 32'h7F);

    // Release with input 0
    #1 reset = 1'b0;
    @(negedge clock);
    check("rel_anode", 32'(anode), 32'hFE);
    check("rel_cathode", 32'(cathode), 32'(P0));
    slot("zero_d1", 8'hFD, PB);
    slot("zero_d2", 8'hFB, PB);
    slot("zero_d3", 8'hF7, PB);
    slot("zero_d4", 8'hEF, PB);

    // 12345
    num = 16'd12345;
    repeat (40) @(negedge clock);
    slot("v12345_d0", 8'hFE, P5);
    slot("v12345_d1", 8'hFD, P4);
    slot("v12345_d2", 8'hFB, P3);
    slot("v12345_d3", 8'hF7, P2);
    slot("v12345_d4", 8'hEF, P1);

    // 65535
    num = 16'd65535;
    repeat (40) @(negedge clock);
    slot("v65535_d0", 8'hFE, P5);
    slot("v65535_d1", 8'hFD, P3);
    slot("v65535_d2", 8'hFB, P5);
    slot("v65535_d3", 8'hF7, P5);
    slot("v65535_d4", 8'hEF, P6);

    // 8 / 16 toggling every 8 cycles: only whole values may appear
    for (int k = 0; k < 10; k++) begin
      num = (k % 2 == 0) ? 16'd8 : 16'd16;
      repeat (8) begin
        @(negedge clock);
        if (anode === 8'hFE)
          check("tog_ones", 32'(cathode inside {P5, P8, P6}), 32'd1);
        if (anode === 8'hFD)
          check("tog_tens", 32'(cathode inside {P3, PB, P1}), 32'd1);
      end
    end
    repeat (40) @(negedge clock);
    slot("v16_d0", 8'hFE, P6);
    slot("v16_d1", 8'hFD, P1);
    slot("v16_d2", 8'hFB, PB);
    slot("v16_d3", 8'hF7, PB);
    slot("v16_d4", 8'hEF, PB);

    // Reset mid-conversion with 999
    @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    #1 reset = 1'b0;
    num = 16'd999;
    @(negedge clock);                    // after sample edge
    check("r999_first_cathode", 32'(cathode), 32'(P0));
    repeat (3) @(negedge clock);         // now in shift
    #2 reset = 1'b1;
    #1;
    check("abort_async_anode", 32'(anode), 32'hFF);
    check("abort_async_cathode", 32'(cathode), 32'h7F);
    @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_d0_anode", 32'(anode), 32'hFE);
    check("abort_d0_cathode", 32'(cathode), 32'(P0));
    repeat (4) @(negedge clock);
    check("abort_d1_anode", 32'(anode), 32'hFD);
    check("abort_d1_cathode", 32'(cathode), 32'(PB));
    repeat (4) @(negedge clock);
    check("abort_d2_anode", 32'(anode), 32'hFB);
    check("abort_d2_cathode", 32'(cathode), 32'(PB));
    slot("v999_d0", 8'hFE, P9);
    slot("v999_d1", 8'hFD, P9);
    slot("v999_d2", 8'hFB, P9);
    slot("v999_d3", 8'hF7, PB);

    check("anode_legal", 32'(bad_anode), 32'd0);
    check("pattern_legal", 32'(bad_pat), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
